// File: rtl/fpu_pkg.sv
// Shared FPU definitions: register-file geometry and a one-hot address decoder
// used by the writeback scoreboard.
package fpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    return {{(NUM_REGS-1){1'b0}}, 1'b1} << addr;
  endfunction

endpackage

// File: rtl/fpu_wb_fifo.sv
// Two-write / one-read circular buffer of writeback results. Write port 0 is
// enqueued ahead of write port 1 when both are active in the same cycle.
module fpu_wb_fifo
  import fpu_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr0_en,
  input  logic [REG_ADDR_W-1:0]   wr0_addr,
  input  logic [DW-1:0]           wr0_data,
  input  logic                    wr1_en,
  input  logic [REG_ADDR_W-1:0]   wr1_addr,
  input  logic [DW-1:0]           wr1_data,
  input  logic                    rd_en,
  output logic [REG_ADDR_W-1:0]   head_addr,
  output logic [DW-1:0]           head_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REG_ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DW-1:0]         data_mem_q [DEPTH];

  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic                  slot0_en_s, slot1_en_s;
  logic [REG_ADDR_W-1:0] slot0_addr_s;
  logic [DW-1:0]         slot0_data_s;
  logic [PW-1:0]         wptr_p1_s;

  // Compact the two write ports so a lone port-1 write still lands at the tail.
  always_comb begin
    slot0_en_s = wr0_en | wr1_en;
    slot1_en_s = wr0_en & wr1_en;
    if (wr0_en) begin
      slot0_addr_s = wr0_addr;
      slot0_data_s = wr0_data;
    end else begin
      slot0_addr_s = wr1_addr;
      slot0_data_s = wr1_data;
    end
    wptr_p1_s = wptr_q + PW'(1'b1);
    wptr_d    = wptr_q + PW'(slot0_en_s) + PW'(slot1_en_s);
    rptr_d    = rptr_q + PW'(rd_en);
    count_d   = count_q + CW'(slot0_en_s) + CW'(slot1_en_s) - CW'(rd_en);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are qualified by count so they need no reset.
  always_ff @(posedge clk) begin
    if (slot0_en_s) begin
      addr_mem_q[wptr_q] <= slot0_addr_s;
      data_mem_q[wptr_q] <= slot0_data_s;
    end
    if (slot1_en_s) begin
      addr_mem_q[wptr_p1_s] <= wr1_addr;
      data_mem_q[wptr_p1_s] <= wr1_data;
    end
  end

  assign head_addr = addr_mem_q[rptr_q];
  assign head_data = data_mem_q[rptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fpu_wb_arbiter.sv
// Writeback arbiter: merges fast-pipe and slow-unit results into the register
// file write port and tracks destinations with results outstanding.
module fpu_wb_arbiter
  import fpu_pkg::*;
#(
  parameter int num_bits = 32,
  parameter int DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid,
  input  logic [REG_ADDR_W-1:0]   issue_addr,
  input  logic                    fast_valid,
  input  logic [REG_ADDR_W-1:0]   fast_addr,
  input  logic [num_bits-1:0]     fast_data,
  output logic                    fast_ready,
  input  logic                    slow_valid,
  input  logic [REG_ADDR_W-1:0]   slow_addr,
  input  logic [num_bits-1:0]     slow_data,
  output logic                    slow_ready,
  output logic                    wb_en,
  output logic [REG_ADDR_W-1:0]   wb_addr,
  output logic [num_bits-1:0]     wb_data,
  output logic [NUM_REGS-1:0]     busy_mask,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LIM_ONE = CW'(DEPTH - 1);
  localparam logic [CW-1:0] LIM_TWO = CW'(DEPTH - 2);

  logic [CW-1:0]         count_s;
  logic                  fast_ready_s, slow_ready_s;
  logic                  fast_accept_s, slow_accept_s;
  logic                  wb_en_s;
  logic [REG_ADDR_W-1:0] head_addr_s;
  logic [num_bits-1:0]   head_data_s;
  logic [NUM_REGS-1:0]   busy_set_s, busy_clr_s;
  logic [NUM_REGS-1:0]   busy_q, busy_d;

  // Admission uses only the registered count; fast owns the last free slot.
  always_comb begin
    fast_ready_s  = (count_s <= LIM_ONE);
    slow_ready_s  = (count_s <= LIM_TWO) || (!fast_valid && (count_s <= LIM_ONE));
    fast_accept_s = fast_valid & fast_ready_s;
    slow_accept_s = slow_valid & slow_ready_s;
    wb_en_s       = (count_s != {CW{1'b0}});
  end

  fpu_wb_fifo #(
    .DW    (num_bits),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .wr0_en    (fast_accept_s),
    .wr0_addr  (fast_addr),
    .wr0_data  (fast_data),
    .wr1_en    (slow_accept_s),
    .wr1_addr  (slow_addr),
    .wr1_data  (slow_data),
    .rd_en     (wb_en_s),
    .head_addr (head_addr_s),
    .head_data (head_data_s),
    .count     (count_s)
  );

  // Scoreboard update: an issue in the same cycle as the writeback keeps the bit set.
  always_comb begin
    if (issue_valid) begin
      busy_set_s = reg_onehot(issue_addr);
    end else begin
      busy_set_s = {NUM_REGS{1'b0}};
    end
    if (wb_en_s) begin
      busy_clr_s = reg_onehot(head_addr_s);
    end else begin
      busy_clr_s = {NUM_REGS{1'b0}};
    end
    busy_d = (busy_q & ~busy_clr_s) | busy_set_s;
  end

  // Busy-mask register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= {NUM_REGS{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  assign fast_ready = fast_ready_s;
  assign slow_ready = slow_ready_s;
  assign wb_en      = wb_en_s;
  assign wb_addr    = head_addr_s;
  assign wb_data    = head_data_s;
  assign busy_mask  = busy_q;
  assign occupancy  = count_s;

endmodule

// File: tb/tb_fpu_wb_arbiter.sv
// Directed bench for fpu_wb_arbiter: expected writebacks are queued as results
// are offered; a monitor pops and compares them whenever wb_en is seen.
module tb_fpu_wb_arbiter;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        fast_valid;
  logic [4:0]  fast_addr;
  logic [31:0] fast_data;
  logic        fast_ready;
  logic        slow_valid;
  logic [4:0]  slow_addr;
  logic [31:0] slow_data;
  logic        slow_ready;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] busy_mask;
  logic [2:0]  occupancy;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] rf [32];
  int          wr_cnt   = 0;
  int          wr_snap  = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  fpu_wb_arbiter #(.num_bits(32), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .fast_valid  (fast_valid),
    .fast_addr   (fast_addr),
    .fast_data   (fast_data),
    .fast_ready  (fast_ready),
    .slow_valid  (slow_valid),
    .slow_addr   (slow_addr),
    .slow_data   (slow_data),
    .slow_ready  (slow_ready),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .busy_mask   (busy_mask),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic drive_fast(input logic [4:0] a, input logic [31:0] d);
    fast_valid = 1'b1;
    fast_addr  = a;
    fast_data  = d;
  endtask

  task automatic drive_slow(input logic [4:0] a, input logic [31:0] d);
    slow_valid = 1'b1;
    slow_addr  = a;
    slow_data  = d;
  endtask

  // Register-file model fed by the write port.
  always @(posedge clk) begin
    if (rst && wb_en) begin
      rf[wb_addr] <= wb_data;
      wr_cnt      <= wr_cnt + 1;
    end
  end

  // Writeback monitor.
  always @(negedge clk) begin
    if (rst && wb_en) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_wb: got addr %0d data 0x%0h, expected no write", wb_addr, wb_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_addr", 32'(wb_addr), 32'(mon_e.a));
        chk("wb_data", wb_data, mon_e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b0;
    issue_valid = 1'b0; issue_addr = 5'd0;
    fast_valid = 1'b0;  fast_addr = 5'd0; fast_data = 32'd0;
    slow_valid = 1'b0;  slow_addr = 5'd0; slow_data = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_fast_ready", 32'(fast_ready), 32'd1);
    chk("rst_slow_ready", 32'(slow_ready), 32'd1);
    chk("rst_busy", busy_mask, 32'd0);
    rst = 1'b1;

    // Single fast result with issue one cycle earlier
    issue_valid = 1'b1; issue_addr = 5'd3;
    @(negedge clk);
    issue_valid = 1'b0;
    chk("t1_busy_set", 32'(busy_mask[3]), 32'd1);
    drive_fast(5'd3, 32'h3F80_0000); push(5'd3, 32'h3F80_0000);
    @(negedge clk);
    fast_valid = 1'b0;
    chk("t1_wb_en", 32'(wb_en), 32'd1);
    chk("t1_busy_held", 32'(busy_mask[3]), 32'd1);
    @(negedge clk);
    chk("t1_busy_clr", 32'(busy_mask[3]), 32'd0);
    chk("t1_rf3", rf[3], 32'h3F80_0000);

    // Simultaneous fast and slow into empty FIFO
    drive_fast(5'd1, 32'h11); push(5'd1, 32'h11);
    drive_slow(5'd2, 32'h22); push(5'd2, 32'h22);
    #1 chk("t2_slow_ready", 32'(slow_ready), 32'd1);
    @(negedge clk);
    fast_valid = 1'b0; slow_valid = 1'b0;
    chk("t2_occ2", 32'(occupancy), 32'd2);
    @(negedge clk);
    chk("t2_occ1", 32'(occupancy), 32'd1);
    @(negedge clk);
    chk("t2_occ0", 32'(occupancy), 32'd0);

    // Fill to three, then contend for the last slot
    drive_fast(5'd8, 32'h80);  push(5'd8, 32'h80);
    drive_slow(5'd9, 32'h90);  push(5'd9, 32'h90);
    @(negedge clk);
    chk("t3_occ2", 32'(occupancy), 32'd2);
    drive_fast(5'd10, 32'hA0); push(5'd10, 32'hA0);
    drive_slow(5'd11, 32'hB0); push(5'd11, 32'hB0);
    #1 chk("t3_slow_ready_c2", 32'(slow_ready), 32'd1);
    @(negedge clk);
    chk("t3_occ3", 32'(occupancy), 32'd3);
    drive_fast(5'd12, 32'hC0); push(5'd12, 32'hC0);
    drive_slow(5'd13, 32'hD0);
    #1 chk("t3_fast_ready_c3", 32'(fast_ready), 32'd1);
    chk("t3_slow_ready_c3", 32'(slow_ready), 32'd0);
    @(negedge clk);
    fast_valid = 1'b0;
    push(5'd13, 32'hD0);
    chk("t3_occ3_after_fast", 32'(occupancy), 32'd3);
    #1 chk("t3_slow_ready_alone", 32'(slow_ready), 32'd1);
    @(negedge clk);
    slow_valid = 1'b0;
    chk("t3_occ3_after_slow", 32'(occupancy), 32'd3);
    n = 0;
    while (occupancy != 3'd0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("t3_drain", 32'(occupancy), 32'd0);

    // Re-issue to the address being written back stays busy
    drive_fast(5'd5, 32'h55); push(5'd5, 32'h55);
    @(negedge clk);
    fast_valid = 1'b0;
    chk("t4_wb_en", 32'(wb_en), 32'd1);
    issue_valid = 1'b1; issue_addr = 5'd5;
    @(negedge clk);
    issue_valid = 1'b0;
    chk("t4_busy5", 32'(busy_mask[5]), 32'd1);
    chk("t4_occ0", 32'(occupancy), 32'd0);

    // Two results to the same register, later one wins
    drive_fast(5'd7, 32'hA); push(5'd7, 32'hA);
    drive_slow(5'd7, 32'hB); push(5'd7, 32'hB);
    @(negedge clk);
    fast_valid = 1'b0; slow_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_rf7", rf[7], 32'hB);

    // Reset with three queued entries and busy bits 4..7
    issue_valid = 1'b1; issue_addr = 5'd4;
    drive_fast(5'd20, 32'h200); push(5'd20, 32'h200);
    drive_slow(5'd21, 32'h210); push(5'd21, 32'h210);
    @(negedge clk);
    issue_addr = 5'd6;
    drive_fast(5'd22, 32'h220); push(5'd22, 32'h220);
    drive_slow(5'd23, 32'h230); push(5'd23, 32'h230);
    @(negedge clk);
    issue_addr = 5'd7;
    slow_valid = 1'b0;
    drive_fast(5'd24, 32'h240); push(5'd24, 32'h240);
    @(negedge clk);
    issue_valid = 1'b0; fast_valid = 1'b0;
    chk("t6_occ3", 32'(occupancy), 32'd3);
    chk("t6_busy_f0", busy_mask, 32'h0000_00F0);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_occ", 32'(occupancy), 32'd0);
    chk("t6_rst_busy", busy_mask, 32'd0);
    chk("t6_rst_wb_en", 32'(wb_en), 32'd0);
    exp_q.delete();
    wr_snap = wr_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_no_writes", 32'(wr_cnt - wr_snap), 32'd0);
    chk("t6_occ_idle", 32'(occupancy), 32'd0);

    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fpu_wb_arbiter.md
# fpu_wb_arbiter

Writeback arbiter and scoreboard sitting directly upstream of the FPU register file's single write port. Accepts results from two FPU execution sources (fast pipe: add/mul; slow unit: div/sqrt) through a shared 2-write/1-read FIFO. Drains the FIFO one result per cycle into the register file. Maintains a 32-bit busy mask of destination registers with results outstanding, for use by issue logic.

## Interface
Parameters:
- num_bits, 32, data width; matches the register file
- DEPTH, 4, FIFO entries; power of two, ≥ 2

Ports:
- clk  in  1  clock; all state on posedge
- rst  in  1  asynchronous, active-low reset
- issue_valid  in  1  an op with FPU destination is issued this cycle
- issue_addr  in  5  destination register of the issued op
- fast_valid  in  1  fast-pipe result valid
- fast_addr  in  5  fast-pipe destination
- fast_data  in  num_bits  fast-pipe result
- fast_ready  out  1  fast-pipe result accepted when valid && ready
- slow_valid  in  1  slow-unit result valid
- slow_addr  in  5  slow-unit destination
- slow_data  in  num_bits  slow-unit result
- slow_ready  out  1  slow-unit result accepted when valid && ready
- wb_en  out  1  register-file write_enable
- wb_addr  out  5  register-file write_addr
- wb_data  out  num_bits  register-file write_data
- busy_mask  out  32  bit i = 1 while register i has a result pending
- occupancy  out  $clog2(DEPTH)+1  current FIFO entry count

## Operation
- count = registered FIFO occupancy; ready signals never depend on this cycle's dequeue.
- fast_ready = (count ≤ DEPTH-1).
- slow_ready = (count ≤ DEPTH-2) || (!fast_valid && count ≤ DEPTH-1). The fast pipe has priority for the last free slot.
- When both are accepted in one cycle: fast is enqueued first, slow second.
- Dequeue: wb_en = (count != 0); wb_addr/wb_data = head entry, combinational from FIFO storage. The head is popped at every edge where wb_en=1. The register file has no backpressure.
- Count update per edge: count + accepted_inputs − wb_en. Range 0..DEPTH, never exceeded by construction.
- Pointers wrap modulo DEPTH. Full is distinguished from empty by count, not by pointer equality.
- Scoreboard, per edge:
  - issue_valid sets busy_mask[issue_addr].
  - wb_en clears busy_mask[wb_addr].
  - Set and clear to the same address in the same cycle: set wins (a WAW re-issue stays busy).
- Register 0 is an ordinary register; no special casing.
- Two queued results for the same address are written in FIFO order; the later one wins in the register file.
- busy_mask is bookkeeping only. No input is blocked by it.

## Timing
- Reset (rst=0, asynchronous): count=0, pointers=0, busy_mask=0, wb_en=0, fast_ready=1, slow_ready=1, occupancy=0. FIFO data is not reset; wb_addr/wb_data are don't-care while wb_en=0.
- Reset asserted mid-operation discards all queued results and clears busy_mask immediately. No wb_en after assertion.
- Deassertion of reset is assumed synchronised externally. The first accept can occur at the first edge with rst=1.
- Latency: a result accepted at edge N appears on wb_* during cycle N (after the edge) if the FIFO was empty. The register file captures it at edge N+1. busy_mask for that address clears at edge N+1.
- Throughput: sustained 1 result/cycle. A 2-result burst is absorbed while count ≤ DEPTH-2.
- With DEPTH=4 and both sources streaming, steady state alternates fast accepts; slow stalls only when count=DEPTH-1 and fast_valid=1.

## Structure
- fpu_pkg (shared):
  - localparam REG_ADDR_W=5, NUM_REGS=32
  - typedef wb_entry_t packed struct {addr[4:0], data[num_bits-1:0]} (parameterised via the module instantiating it, or as separate addr/data arrays if the package cannot carry num_bits)
- Sub-module fpu_wb_fifo: 2-write/1-read circular buffer with count output. The arbiter instantiates it and adds the ready logic and scoreboard.

## Test plan
- Reset then single fast result (addr 3, data 0x3F800000), issued one cycle earlier:
  - busy_mask[3]=1 after issue
  - wb_en=1, wb_addr=3, wb_data=0x3F800000 one cycle after accept
  - busy_mask[3]=0 the next edge
  - regfile reads 0x3F800000
- Simultaneous fast (addr 1, 0x11) and slow (addr 2, 0x22) into an empty FIFO:
  - wb sequence is addr 1 then addr 2 on consecutive cycles
  - occupancy goes 2→1→0
- Fill FIFO to 3 (DEPTH=4), then fast_valid and slow_valid together:
  - fast_ready=1, slow_ready=0
  - next cycle count=3 (one in, one out), slow accepted
- issue_valid on addr 5 in the same cycle as wb_en for addr 5: busy_mask[5] stays 1.
- Two queued results to addr 7 (0xA, then 0xB): regfile addr 7 ends at 0xB.
- Assert rst with 3 entries queued and busy_mask=0x0000_00F0:
  - immediately count=0, busy_mask=0, wb_en=0
  - no writes occur after rst deasserts.
